// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result checker: opcodes, FSM states, default width.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [3:0] ALU_SUB = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_DEC = 4'd4;
    localparam logic [3:0] ALU_INC = 4'd5;
    localparam logic [3:0] ALU_INV = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SLA = 4'd9;
    localparam logic [3:0] ALU_SRA = 4'd10;
    localparam logic [3:0] ALU_SLT = 4'd11;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference ALU: expected result, signed overflow and zero for one opcode.
module alu_golden_model
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] exp_s,
    output logic             exp_ovf,
    output logic             exp_zero,
    output logic             supported
);

    localparam int unsigned MSB = WIDTH - 1;

    always_comb begin
        exp_s     = '0;
        exp_ovf   = 1'b0;
        supported = 1'b1;
        case (ctrl)
            ALU_SUB: begin
                exp_s   = a - b;
                exp_ovf = (a[MSB] != b[MSB]) && (exp_s[MSB] != a[MSB]);
            end
            ALU_ADD: begin
                exp_s   = a + b;
                exp_ovf = (a[MSB] == b[MSB]) && (exp_s[MSB] != a[MSB]);
            end
            ALU_OR:  exp_s = a | b;
            ALU_AND: exp_s = a & b;
            // Implicit operand 1 is positive: DEC only overflows from a negative a.
            ALU_DEC: begin
                exp_s   = a - 1'b1;
                exp_ovf = a[MSB] && !exp_s[MSB];
            end
            ALU_INC: begin
                exp_s   = a + 1'b1;
                exp_ovf = !a[MSB] && exp_s[MSB];
            end
            ALU_INV: exp_s = ~a;
            ALU_SLL, ALU_SLA: exp_s = a << b[3:0];
            ALU_SRL: exp_s = a >> b[3:0];
            ALU_SRA: exp_s = $signed(a) >>> b[3:0];
            ALU_SLT: exp_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: supported = 1'b0;
        endcase
    end

    assign exp_zero = (exp_s == '0);

endmodule

// File: rtl/alu_result_checker.sv
// Two-stage self-checking monitor for the ALU with pass/fail/skip stats and first-fail capture.
// Optional macro ALU_CHECK_STOP_ON_FAIL_EN: halt checking after the first failing transaction.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] s,
    input  logic             overflow,
    input  logic             zero,
    output logic             running,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic [3:0]       ff_ctrl,
    output logic [WIDTH-1:0] ff_s
);

    state_t           state;
    logic             v1;
    logic [WIDTH-1:0] a1, b1, s1;
    logic [3:0]       ctrl1;
    logic             ovf1, zero1;

    logic [WIDTH-1:0] exp_s;
    logic             exp_ovf, exp_zero, supported;
    logic             match;

    alu_golden_model #(
        .WIDTH(WIDTH)
    ) u_golden (
        .a        (a1),
        .b        (b1),
        .ctrl     (ctrl1),
        .exp_s    (exp_s),
        .exp_ovf  (exp_ovf),
        .exp_zero (exp_zero),
        .supported(supported)
    );

    assign match = (s1 == exp_s) && (ovf1 == exp_ovf) && (zero1 == exp_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            v1       <= 1'b0;
            a1       <= '0;
            b1       <= '0;
            s1       <= '0;
            ctrl1    <= '0;
            ovf1     <= 1'b0;
            zero1    <= 1'b0;
            err      <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            skip_cnt <= '0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_ctrl  <= '0;
            ff_s     <= '0;
        end else if (start) begin
            state    <= RUN;
            v1       <= 1'b0;
            err      <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            skip_cnt <= '0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_ctrl  <= '0;
            ff_s     <= '0;
        end else begin
            v1    <= in_valid && (state == RUN);
            a1    <= a;
            b1    <= b;
            s1    <= s;
            ctrl1 <= ctrl;
            ovf1  <= overflow;
            zero1 <= zero;
            // Stage 2 scores whatever is in stage 1, even if the FSM has just halted.
            if (v1) begin
                if (!supported) begin
                    if (skip_cnt != '1) skip_cnt <= skip_cnt + 1'b1;
                end else if (match) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                    err <= 1'b1;
                    if (!err) begin
                        ff_a    <= a1;
                        ff_b    <= b1;
                        ff_ctrl <= ctrl1;
                        ff_s    <= s1;
                    end
`ifdef ALU_CHECK_STOP_ON_FAIL_EN
                    if (state == RUN) state <= HALT;
`endif
                end
            end
        end
    end

    assign running = (state == RUN);
`ifdef ALU_CHECK_STOP_ON_FAIL_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker; a second instance with CNT_W=2 checks saturation.
module tb_alu_result_checker;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst, start, in_valid;
    logic [W-1:0] a, b, s;
    logic [3:0]   ctrl;
    logic         overflow, zero;

    logic         running, halted, err;
    logic [15:0]  pass_cnt, fail_cnt, skip_cnt;
    logic [W-1:0] ff_a, ff_b, ff_s;
    logic [3:0]   ff_ctrl;

    logic         running2, halted2, err2;
    logic [1:0]   pass_cnt2, fail_cnt2, skip_cnt2;
    logic [W-1:0] ff_a2, ff_b2, ff_s2;
    logic [3:0]   ff_ctrl2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_result_checker #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .ctrl(ctrl), .s(s), .overflow(overflow), .zero(zero),
        .running(running), .halted(halted), .err(err),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
        .ff_a(ff_a), .ff_b(ff_b), .ff_ctrl(ff_ctrl), .ff_s(ff_s)
    );

    alu_result_checker #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .a(a), .b(b), .ctrl(ctrl), .s(s), .overflow(overflow), .zero(zero),
        .running(running2), .halted(halted2), .err(err2),
        .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .skip_cnt(skip_cnt2),
        .ff_a(ff_a2), .ff_b(ff_b2), .ff_ctrl(ff_ctrl2), .ff_s(ff_s2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one transaction, then wait until it has been scored in stage 2.
    task automatic send(input logic [3:0] c, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] vs, input logic vo, input logic vz);
        @(negedge clk);
        ctrl = c; a = va; b = vb; s = vs; overflow = vo; zero = vz;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; s = '0; ctrl = '0; overflow = 1'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_running", running, 0);
        chk("reset_halted", halted, 0);
        chk("reset_pass", pass_cnt, 0);
        chk("reset_err", err, 0);

        send(4'd1, 16'd2, 16'd5, 16'd7, 1'b0, 1'b0);
        chk("idle_ignored_pass", pass_cnt, 0);

        pulse_start();
        chk("start_running", running, 1);

        send(4'd1, 16'd2, 16'd5, 16'd7, 1'b0, 1'b0);
        chk("add_2_5_pass", pass_cnt, 1);
        chk("add_2_5_err", err, 0);

        send(4'd1, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0);
        chk("add_ovf_pass", pass_cnt, 2);

        send(4'd1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0);
        chk("add_ovf_bad_fail", fail_cnt, 1);
        chk("first_fail_err", err, 1);
        chk("ff_a", ff_a, 16'h7FFF);
        chk("ff_b", ff_b, 16'h0001);
        chk("ff_ctrl", ff_ctrl, 4'd1);
        chk("ff_s", ff_s, 16'h8000);

`ifdef ALU_CHECK_STOP_ON_FAIL_EN
        chk("stop_halted", halted, 1);
        chk("stop_running", running, 0);
        send(4'd1, 16'd2, 16'd5, 16'd7, 1'b0, 1'b0);
        chk("stop_pass_frozen", pass_cnt, 2);
        pulse_start();
        chk("restart_running", running, 1);
        chk("restart_pass", pass_cnt, 0);
        chk("restart_fail", fail_cnt, 0);
        chk("restart_err", err, 0);
`else
        chk("nostop_halted", halted, 0);
        chk("nostop_running", running, 1);

        send(4'd0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0);
        chk("sub_ovf_pass", pass_cnt, 3);
        send(4'd1, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        chk("add_zero_pass", pass_cnt, 4);

        send(4'd1, 16'd2, 16'd5, 16'd8, 1'b0, 1'b0);
        chk("second_fail_cnt", fail_cnt, 2);
        chk("second_fail_ff_a", ff_a, 16'h7FFF);
        chk("second_fail_ff_s", ff_s, 16'h8000);

        send(4'd1, 16'd2, 16'd5, 16'd7, 1'b0, 1'b1);
        chk("bad_zero_fail", fail_cnt, 3);

        send(4'd15, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1);
        chk("skip_cnt", skip_cnt, 1);
        chk("skip_pass_same", pass_cnt, 4);
        chk("skip_fail_same", fail_cnt, 3);

        send(4'd11, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
        chk("slt_pass", pass_cnt, 5);
        send(4'd10, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0);
        chk("sra_pass", pass_cnt, 6);
        send(4'd7, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0);
        chk("sll_pass", pass_cnt, 7);
        send(4'd5, 16'h7FFF, 16'h0000, 16'h8000, 1'b1, 1'b0);
        chk("inc_ovf_pass", pass_cnt, 8);
        send(4'd4, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
        chk("dec_pass", pass_cnt, 9);
        send(4'd6, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0);
        chk("inv_pass", pass_cnt, 10);
        send(4'd8, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0);
        chk("srl_pass", pass_cnt, 11);
        chk("sat_pass_cnt2", pass_cnt2, 3);
        chk("sat_fail_cnt2", fail_cnt2, 3);

        // Sample in stage 1 when rst hits must be dropped.
        @(negedge clk);
        ctrl = 4'd1; a = 16'd2; b = 16'd5; s = 16'd7; overflow = 1'b0; zero = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_ff_a", ff_a, 0);
        chk("rst_running", running, 0);
`endif

        pulse_start();
        repeat (2) @(negedge clk);
        chk("final_pass", pass_cnt, 0);
        chk("final_skip", skip_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
